// File: rtl/dual_tag_pkg.sv
// rtl/dual_tag_pkg.sv - shared defaults and types for the dual-port tag table
package dual_tag_pkg;
  localparam int NUM_SLOTS_D = 8;
  localparam int TAG_W_D     = 16;
  localparam int STALL_W     = 16;

  typedef logic [TAG_W_D-1:0]            tag_t;
  typedef logic [$clog2(NUM_SLOTS_D)-1:0] slot_idx_t;
endpackage

// File: rtl/dual_tag_slot_pick.sv
// rtl/dual_tag_slot_pick.sv - lowest-index picker over a slot eligibility vector
module dual_tag_slot_pick
  import dual_tag_pkg::*;
#(
  parameter int  NUM_SLOTS = NUM_SLOTS_D,
  localparam int IDX_W     = $clog2(NUM_SLOTS)
) (
  input  logic [NUM_SLOTS-1:0] elig,
  output logic                 found,
  output logic [IDX_W-1:0]     idx
);

  // Scan from the top so the last hit, i.e. the lowest eligible index, wins.
  always_comb begin
    found = |elig;
    idx   = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (elig[i]) idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/dual_tag_table.sv
// rtl/dual_tag_table.sv - dual-port tag table that never holds equal valid tags in one slot on both sides
// Optional saturating stall counters enabled by DUAL_TAG_TABLE_STATS_EN.
module dual_tag_table
  import dual_tag_pkg::*;
#(
  parameter int  NUM_SLOTS = NUM_SLOTS_D,
  parameter int  TAG_W     = TAG_W_D,
  localparam int IDX_W     = $clog2(NUM_SLOTS),
  localparam int OCC_W     = IDX_W + 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       alloc_valid_a,
  input  logic [TAG_W-1:0]           alloc_tag_a,
  output logic                       alloc_ready_a,
  output logic [IDX_W-1:0]           alloc_idx_a,
  input  logic                       alloc_valid_b,
  input  logic [TAG_W-1:0]           alloc_tag_b,
  output logic                       alloc_ready_b,
  output logic [IDX_W-1:0]           alloc_idx_b,
  input  logic                       rel_valid_a,
  input  logic [IDX_W-1:0]           rel_idx_a,
  input  logic                       rel_valid_b,
  input  logic [IDX_W-1:0]           rel_idx_b,
  output logic [NUM_SLOTS-1:0]       vld_a,
  output logic [NUM_SLOTS*TAG_W-1:0] tag_a,
  output logic [NUM_SLOTS-1:0]       vld_b,
  output logic [NUM_SLOTS*TAG_W-1:0] tag_b,
  output logic [OCC_W-1:0]           occ_a,
  output logic [OCC_W-1:0]           occ_b,
  output logic [STALL_W-1:0]         stall_a,
  output logic [STALL_W-1:0]         stall_b
);

  logic [NUM_SLOTS-1:0] elig_a, elig_b, elig_b_masked;
  logic                 found_b, found_bm;
  logic [IDX_W-1:0]     idx_b, idx_bm;
  logic                 fire_a, fire_b, rel_eff_a, rel_eff_b, mask_b;

  // A slot is barred for one side while the other side holds the same tag there.
  always_comb begin
    elig_a = '0;
    elig_b = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      elig_a[i] = !vld_a[i] && !(vld_b[i] && (tag_b[i*TAG_W +: TAG_W] == alloc_tag_a));
      elig_b[i] = !vld_b[i] && !(vld_a[i] && (tag_a[i*TAG_W +: TAG_W] == alloc_tag_b));
    end
  end

  assign elig_b_masked = elig_b & ~(NUM_SLOTS'(1) << alloc_idx_a);

  dual_tag_slot_pick #(.NUM_SLOTS(NUM_SLOTS)) u_pick_a (
    .elig  (elig_a),
    .found (alloc_ready_a),
    .idx   (alloc_idx_a)
  );

  dual_tag_slot_pick #(.NUM_SLOTS(NUM_SLOTS)) u_pick_b (
    .elig  (elig_b),
    .found (found_b),
    .idx   (idx_b)
  );

  dual_tag_slot_pick #(.NUM_SLOTS(NUM_SLOTS)) u_pick_bm (
    .elig  (elig_b_masked),
    .found (found_bm),
    .idx   (idx_bm)
  );

  // A wins a same-cycle, same-tag race; B then skips A's slot.
  assign fire_a        = alloc_valid_a && alloc_ready_a;
  assign mask_b        = fire_a && (alloc_tag_a == alloc_tag_b);
  assign alloc_ready_b = mask_b ? found_bm : found_b;
  assign alloc_idx_b   = mask_b ? idx_bm : idx_b;
  assign fire_b        = alloc_valid_b && alloc_ready_b;

  assign rel_eff_a = rel_valid_a && vld_a[rel_idx_a];
  assign rel_eff_b = rel_valid_b && vld_b[rel_idx_b];

  // An allocated slot is never valid, so it cannot collide with a release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_a <= '0;
      tag_a <= '0;
      occ_a <= '0;
    end else begin
      if (rel_eff_a) begin
        vld_a[rel_idx_a]               <= 1'b0;
        tag_a[rel_idx_a*TAG_W +: TAG_W] <= '0;
      end
      if (fire_a) begin
        vld_a[alloc_idx_a]               <= 1'b1;
        tag_a[alloc_idx_a*TAG_W +: TAG_W] <= alloc_tag_a;
      end
      occ_a <= occ_a + OCC_W'(fire_a) - OCC_W'(rel_eff_a);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_b <= '0;
      tag_b <= '0;
      occ_b <= '0;
    end else begin
      if (rel_eff_b) begin
        vld_b[rel_idx_b]               <= 1'b0;
        tag_b[rel_idx_b*TAG_W +: TAG_W] <= '0;
      end
      if (fire_b) begin
        vld_b[alloc_idx_b]               <= 1'b1;
        tag_b[alloc_idx_b*TAG_W +: TAG_W] <= alloc_tag_b;
      end
      occ_b <= occ_b + OCC_W'(fire_b) - OCC_W'(rel_eff_b);
    end
  end

`ifdef DUAL_TAG_TABLE_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_a <= '0;
      stall_b <= '0;
    end else begin
      if (alloc_valid_a && !alloc_ready_a && (stall_a != '1)) stall_a <= stall_a + 1'b1;
      if (alloc_valid_b && !alloc_ready_b && (stall_b != '1)) stall_b <= stall_b + 1'b1;
    end
  end
`else
  assign stall_a = '0;
  assign stall_b = '0;
`endif

endmodule

// File: tb/tb_dual_tag_table.sv
// tb/tb_dual_tag_table.sv - self-checking bench for dual_tag_table
// Tracks the stall counters when DUAL_TAG_TABLE_STATS_EN is defined.
module tb_dual_tag_table;
  localparam int NS = 8;
  localparam int TW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          alloc_valid_a, alloc_valid_b;
  logic [TW-1:0] alloc_tag_a, alloc_tag_b;
  logic          alloc_ready_a, alloc_ready_b;
  logic [2:0]    alloc_idx_a, alloc_idx_b;
  logic          rel_valid_a, rel_valid_b;
  logic [2:0]    rel_idx_a, rel_idx_b;
  logic [NS-1:0] vld_a, vld_b;
  logic [NS*TW-1:0] tag_a, tag_b;
  logic [3:0]    occ_a, occ_b;
  logic [15:0]   stall_a, stall_b;

  always #5 clk = ~clk;

  dual_tag_table #(.NUM_SLOTS(NS), .TAG_W(TW)) dut (
    .clk(clk), .rst(rst),
    .alloc_valid_a(alloc_valid_a), .alloc_tag_a(alloc_tag_a),
    .alloc_ready_a(alloc_ready_a), .alloc_idx_a(alloc_idx_a),
    .alloc_valid_b(alloc_valid_b), .alloc_tag_b(alloc_tag_b),
    .alloc_ready_b(alloc_ready_b), .alloc_idx_b(alloc_idx_b),
    .rel_valid_a(rel_valid_a), .rel_idx_a(rel_idx_a),
    .rel_valid_b(rel_valid_b), .rel_idx_b(rel_idx_b),
    .vld_a(vld_a), .tag_a(tag_a), .vld_b(vld_b), .tag_b(tag_b),
    .occ_a(occ_a), .occ_b(occ_b), .stall_a(stall_a), .stall_b(stall_b)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Table model: per-slot valid/tag per side plus stall tallies.
  logic          m_vld_a[NS], m_vld_b[NS];
  logic [TW-1:0] m_tag_a[NS], m_tag_b[NS];
  int            m_stall_a, m_stall_b;
  logic          exp_rdy_a, exp_rdy_b;
  logic [2:0]    exp_idx_a, exp_idx_b;

  always_comb begin
    exp_rdy_a = 1'b0;
    exp_idx_a = '0;
    exp_rdy_b = 1'b0;
    exp_idx_b = '0;
    for (int i = 0; i < NS; i++) begin
      if (!exp_rdy_a && !m_vld_a[i] && !(m_vld_b[i] && m_tag_b[i] == alloc_tag_a)) begin
        exp_rdy_a = 1'b1;
        exp_idx_a = 3'(i);
      end
    end
    for (int i = 0; i < NS; i++) begin
      if (!exp_rdy_b && !m_vld_b[i] && !(m_vld_a[i] && m_tag_a[i] == alloc_tag_b) &&
          !(alloc_valid_a && exp_rdy_a && alloc_tag_a == alloc_tag_b && exp_idx_a == 3'(i))) begin
        exp_rdy_b = 1'b1;
        exp_idx_b = 3'(i);
      end
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NS; i++) begin
        m_vld_a[i] <= 1'b0; m_tag_a[i] <= '0;
        m_vld_b[i] <= 1'b0; m_tag_b[i] <= '0;
      end
      m_stall_a <= 0;
      m_stall_b <= 0;
    end else begin
      if (rel_valid_a && m_vld_a[rel_idx_a]) begin m_vld_a[rel_idx_a] <= 1'b0; m_tag_a[rel_idx_a] <= '0; end
      if (rel_valid_b && m_vld_b[rel_idx_b]) begin m_vld_b[rel_idx_b] <= 1'b0; m_tag_b[rel_idx_b] <= '0; end
      if (alloc_valid_a && exp_rdy_a) begin m_vld_a[exp_idx_a] <= 1'b1; m_tag_a[exp_idx_a] <= alloc_tag_a; end
      if (alloc_valid_b && exp_rdy_b) begin m_vld_b[exp_idx_b] <= 1'b1; m_tag_b[exp_idx_b] <= alloc_tag_b; end
`ifdef DUAL_TAG_TABLE_STATS_EN
      if (alloc_valid_a && !exp_rdy_a && m_stall_a < 65535) m_stall_a <= m_stall_a + 1;
      if (alloc_valid_b && !exp_rdy_b && m_stall_b < 65535) m_stall_b <= m_stall_b + 1;
`endif
    end
  end

  always @(negedge clk) begin : cmp
    logic [NS-1:0]    va, vb;
    logic [NS*TW-1:0] ta, tb;
    int               oa, ob, clash;
    oa = 0; ob = 0; clash = 0;
    for (int i = 0; i < NS; i++) begin
      va[i] = m_vld_a[i];
      vb[i] = m_vld_b[i];
      ta[i*TW +: TW] = m_tag_a[i];
      tb[i*TW +: TW] = m_tag_b[i];
      oa += int'(m_vld_a[i]);
      ob += int'(m_vld_b[i]);
      if (vld_a[i] && vld_b[i] && tag_a[i*TW +: TW] == tag_b[i*TW +: TW]) clash++;
    end
    chk("vld_a", vld_a, va);
    chk("vld_b", vld_b, vb);
    chk("tag_a", tag_a, ta);
    chk("tag_b", tag_b, tb);
    chk("occ_a", occ_a, oa);
    chk("occ_b", occ_b, ob);
    chk("ready_a", alloc_ready_a, exp_rdy_a);
    chk("ready_b", alloc_ready_b, exp_rdy_b);
    if (exp_rdy_a) chk("idx_a", alloc_idx_a, exp_idx_a);
    if (exp_rdy_b) chk("idx_b", alloc_idx_b, exp_idx_b);
    chk("stall_a", stall_a, m_stall_a);
    chk("stall_b", stall_b, m_stall_b);
    chk("tag_invariant", clash, 0);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alloc_valid_a = 0; alloc_valid_b = 0; rel_valid_a = 0; rel_valid_b = 0;
    alloc_tag_a = '0; alloc_tag_b = '0; rel_idx_a = '0; rel_idx_b = '0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    cyc();
    cyc();
    rst = 0;
  endtask

  initial begin
    idle();
    #2;
    chk("rst_occ_a", occ_a, 0);
    chk("rst_vld_b", vld_b, 0);
    chk("rst_ready_a", alloc_ready_a, 1);
    chk("rst_idx_a", alloc_idx_a, 0);
    cyc();
    cyc();
    rst = 0;

    // First allocation lands in slot 0.
    alloc_valid_a = 1; alloc_tag_a = 16'h1234;
    #1;
    chk("first_ready_a", alloc_ready_a, 1);
    chk("first_idx_a", alloc_idx_a, 0);
    cyc();
    idle();
    chk("first_vld_a", vld_a, 8'h01);
    chk("first_tag_a0", tag_a[15:0], 16'h1234);
    chk("first_occ_a", occ_a, 1);

    // B holds 0x00AA in slot 0, A must skip slot 0 for that tag only.
    do_reset();
    alloc_valid_b = 1; alloc_tag_b = 16'h00AA;
    cyc();
    idle();
    alloc_valid_a = 1; alloc_tag_a = 16'h00AA;
    #1;
    chk("skip_idx_a", alloc_idx_a, 1);
    alloc_tag_a = 16'h00BB;
    #1;
    chk("noskip_idx_a", alloc_idx_a, 0);
    alloc_valid_a = 0;
    cyc();

    // Same tag on both ports in the same cycle.
    do_reset();
    alloc_valid_a = 1; alloc_tag_a = 16'h5555;
    alloc_valid_b = 1; alloc_tag_b = 16'h5555;
    #1;
    chk("race_idx_a", alloc_idx_a, 0);
    chk("race_idx_b", alloc_idx_b, 1);
    cyc();
    idle();
    chk("race_vld_a", vld_a, 8'h01);
    chk("race_vld_b", vld_b, 8'h02);

    // Mixed directed traffic with a small tag alphabet, checked by the model.
    for (int i = 0; i < 24; i++) begin
      alloc_valid_a = (i % 3 != 2);
      alloc_tag_a   = 16'(i % 4);
      alloc_valid_b = (i % 2 == 0);
      alloc_tag_b   = 16'((i + 1) % 4 == 0 ? i % 4 : (i + 1) % 4);
      rel_valid_a   = (i % 4 == 3);
      rel_idx_a     = 3'(i % 8);
      rel_valid_b   = (i % 5 == 4);
      rel_idx_b     = 3'((i * 3) % 8);
      cyc();
    end
    idle();

    // Fill A, hold a request against the full side, then free slot 5.
    do_reset();
    alloc_valid_a = 1;
    for (int i = 0; i < NS; i++) begin
      alloc_tag_a = 16'(16'h0100 + i);
      cyc();
    end
    alloc_tag_a = 16'h0200;
    #1;
    chk("full_ready_a", alloc_ready_a, 0);
    chk("full_occ_a", occ_a, 8);
    cyc(); cyc(); cyc();
`ifdef DUAL_TAG_TABLE_STATS_EN
    chk("stall_a_held", stall_a, 3);
`else
    chk("stall_a_held", stall_a, 0);
`endif
    alloc_valid_a = 0;
    rel_valid_a = 1; rel_idx_a = 3'd5;
    #1;
    chk("rel_same_cycle_ready_a", alloc_ready_a, 0);
    cyc();
    rel_valid_a = 0;
    #1;
    chk("rel_ready_a", alloc_ready_a, 1);
    chk("rel_idx_a", alloc_idx_a, 5);

    // Ignored release on B and simultaneous alloc+release on A.
    alloc_valid_b = 1; alloc_tag_b = 16'h0077;
    cyc();
    idle();
    rel_valid_b = 1; rel_idx_b = 3'd3;
    cyc();
    idle();
    chk("bad_rel_vld_b", vld_b, 8'h01);
    chk("bad_rel_occ_b", occ_b, 1);
    alloc_valid_a = 1; alloc_tag_a = 16'h0300;
    rel_valid_a = 1; rel_idx_a = 3'd0;
    cyc();
    idle();
    chk("both_occ_a", occ_a, 7);
    chk("both_vld_a", vld_a, 8'hFE);

    // Reset mid-fill clears everything before the next edge.
    do_reset();
    alloc_valid_a = 1;
    for (int i = 0; i < 4; i++) begin
      alloc_tag_a = 16'(16'h0400 + i);
      cyc();
    end
    alloc_valid_a = 0;
    #2;
    chk("midfill_occ_a", occ_a, 4);
    rst = 1;
    #1;
    chk("async_vld_a", vld_a, 0);
    chk("async_tag_a", tag_a, 0);
    chk("async_occ_a", occ_a, 0);
    chk("async_ready_a", alloc_ready_a, 1);
    chk("async_idx_a", alloc_idx_a, 0);
    cyc();
    rst = 0;
    alloc_valid_a = 1; alloc_tag_a = 16'h0999;
    #1;
    chk("post_rst_idx_a", alloc_idx_a, 0);
    cyc();
    idle();
    chk("post_rst_vld_a", vld_a, 8'h01);
    cyc();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
